// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer.
//   op_e    : command opcodes carried on req_op.
//   state_e : sequencer FSM states (also visible on dbg_state).
//   OP_W    : width of one requester's opcode field.
package counter_seq_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_HOLD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a last-grant register.
//   clk, rst_  : clock, asynchronous active-low reset
//   req_i      : request bits (bit i = requester i)
//   en_i       : grants may be issued only while high
//   gnt_o      : one-hot grant (zero when disabled or nothing requested)
//   gnt_id_o   : index of the requester that would be / is granted
// After reset the last grant is 1, so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q;
    logic last_d;
    logic fire;

    always_comb begin
        // On a tie the requester not served last wins; otherwise the lone requester.
        if (req_i == 2'b11) begin
            gnt_id_o = ~last_q;
        end else begin
            gnt_id_o = req_i[1];
        end
        fire   = en_i && (req_i != 2'b00);
        gnt_o  = fire ? (gnt_id_o ? 2'b10 : 2'b01) : 2'b00;
        last_d = fire ? gnt_id_o : last_q;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer that turns LOAD/UP/DOWN/HOLD commands from two requesters into
// control strobes for an external up/down counter.
//   clk, rst_            : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake; a command is accepted in
//                          the cycle where valid and ready are both high, and
//                          ready is only ever offered in IDLE to one requester
//   req_op/value/steps   : per-requester command fields, requester i at slice i
//   ld_cnt_, updn_cnt,
//   count_enb, data_in   : counter controls (load is active-low)
//   data_out             : registered counter value fed back
//   busy, done, done_id,
//   result               : status; result shows data_out in the DONE cycle and
//                          then holds it until the next completion
//   dbg_state            : current FSM state
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*OP_W-1:0]    req_op,
    input  logic [2*WIDTH-1:0]   req_value,
    input  logic [2*WIDTH-1:0]   req_steps,
    output logic                 ld_cnt_,
    output logic                 updn_cnt,
    output logic                 count_enb,
    output logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     data_out,
    output logic                 busy,
    output logic                 done,
    output logic                 done_id,
    output logic [WIDTH-1:0]     result,
    output logic [1:0]           dbg_state
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   value_q, value_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic               id_q, id_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [1:0]         gnt;
    logic               gnt_id;
    logic               arb_en;

    // Gating with rst_ keeps ready low throughout reset.
    assign arb_en = (state_q == ST_IDLE) && rst_;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_     (rst_),
        .req_i    (req_valid),
        .en_i     (arb_en),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign req_ready = gnt;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        value_d   = value_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        result_d  = result_q;
        ld_cnt_   = 1'b1;
        count_enb = 1'b0;
        updn_cnt  = 1'b0;
        data_in   = '0;
        done      = 1'b0;
        done_id   = 1'b0;
        result    = result_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    op_d    = op_e'(gnt_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0]);
                    value_d = gnt_id ? req_value[2*WIDTH-1:WIDTH] : req_value[WIDTH-1:0];
                    cnt_d   = gnt_id ? req_steps[2*WIDTH-1:WIDTH] : req_steps[WIDTH-1:0];
                    id_d    = gnt_id;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (op_q == OP_LOAD) begin
                    ld_cnt_ = 1'b0;
                    data_in = value_q;
                    state_d = ST_DONE;
                end else begin
                    // cnt_q holds remaining cycles; zero still costs one idle EXEC cycle.
                    if ((op_q != OP_HOLD) && (cnt_q != '0)) begin
                        count_enb = 1'b1;
                        updn_cnt  = (op_q == OP_UP);
                    end
                    if (cnt_q <= WIDTH'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                done_id  = id_q;
                result   = data_out;
                result_d = data_out;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_LOAD;
            value_q  <= '0;
            cnt_q    <= '0;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    localparam int W = 8;
    localparam logic [1:0] C_LOAD = 2'b00;
    localparam logic [1:0] C_UP   = 2'b01;
    localparam logic [1:0] C_DOWN = 2'b10;
    localparam logic [1:0] C_HOLD = 2'b11;

    logic           clk;
    logic           rst_;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [3:0]     req_op;
    logic [2*W-1:0] req_value;
    logic [2*W-1:0] req_steps;
    logic           ld_cnt_;
    logic           updn_cnt;
    logic           count_enb;
    logic [W-1:0]   data_in;
    logic [W-1:0]   data_out;
    logic           busy;
    logic           done;
    logic           done_id;
    logic [W-1:0]   result;
    logic [1:0]     dbg_state;

    int checks = 0;
    int failures = 0;

    // Reference state: counter value implied by completed commands, last grant.
    logic [W-1:0] model_val;
    logic         model_last;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_value (req_value),
        .req_steps (req_steps),
        .ld_cnt_   (ld_cnt_),
        .updn_cnt  (updn_cnt),
        .count_enb (count_enb),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External counter driven by the sequencer's controls.
    logic [W-1:0] cnt_env;
    always @(posedge clk or negedge rst_) begin
        if (!rst_) cnt_env <= '0;
        else if (!ld_cnt_) cnt_env <= data_in;
        else if (count_enb) cnt_env <= updn_cnt ? cnt_env + W'(1) : cnt_env - W'(1);
    end
    assign data_out = cnt_env;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] predict(input logic [1:0] op, input logic [W-1:0] val,
                                             input int steps, input logic [W-1:0] cur);
        case (op)
            C_LOAD:  return val;
            C_UP:    return cur + W'(steps);
            C_DOWN:  return cur - W'(steps);
            default: return cur;
        endcase
    endfunction

    // Issue one command from requester id starting from IDLE and check every cycle.
    task automatic do_cmd(input int id, input logic [1:0] op, input logic [W-1:0] val,
                          input int steps, input logic [W-1:0] exp_res);
        int   n;
        logic exp_ld, exp_enb;
        n       = (op == C_LOAD || steps == 0) ? 1 : steps;
        exp_ld  = (op == C_LOAD) ? 1'b0 : 1'b1;
        exp_enb = (op == C_UP || op == C_DOWN) && (steps > 0);
        @(negedge clk);
        req_valid                = 2'b00;
        req_valid[id]            = 1'b1;
        req_op[id*2 +: 2]        = op;
        req_value[id*W +: W]     = val;
        req_steps[id*W +: W]     = W'(steps);
        #1;
        check("accept_ready", 32'(req_ready), (id == 1) ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check("exec_busy", 32'(busy), 32'd1);
            check("exec_ld", 32'(ld_cnt_), 32'(exp_ld));
            check("exec_enb", 32'(count_enb), 32'(exp_enb));
            if (exp_enb) check("exec_updn", 32'(updn_cnt), (op == C_UP) ? 32'd1 : 32'd0);
            if (op == C_LOAD) check("exec_din", 32'(data_in), 32'(val));
            check("exec_no_done", 32'(done), 32'd0);
            check("ld_enb_excl", 32'(!ld_cnt_ && count_enb), 32'd0);
        end
        @(negedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_id", 32'(done_id), 32'(id));
        check("done_result", 32'(result), 32'(exp_res));
        check("done_enb", 32'(count_enb), 32'd0);
        @(negedge clk);
        #1;
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_result_held", 32'(result), 32'(exp_res));
        model_val  = exp_res;
        model_last = (id == 1);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        int           id;
        logic [1:0]   op;
        logic [W-1:0] val;
        int           steps;
        logic [W-1:0] exp_res;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   got;
        logic exp_g;

        vecs[0] = '{0, C_LOAD, 8'h3C, 0, 8'h3C};
        vecs[1] = '{0, C_LOAD, 8'hFE, 0, 8'hFE};
        vecs[2] = '{1, C_UP,   8'h00, 3, 8'h01};
        vecs[3] = '{0, C_LOAD, 8'h02, 0, 8'h02};
        vecs[4] = '{1, C_DOWN, 8'h00, 4, 8'hFE};
        vecs[5] = '{0, C_HOLD, 8'h00, 5, 8'hFE};
        vecs[6] = '{1, C_UP,   8'h00, 0, 8'hFE};

        // ---------------- reset ----------------
        rst_      = 1'b0;
        req_valid = 2'b11;
        req_op    = '0;
        req_value = '0;
        req_steps = '0;
        model_val = '0;
        model_last = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ld", 32'(ld_cnt_), 32'd1);
        check("rst_enb", 32'(count_enb), 32'd0);
        check("rst_updn", 32'(updn_cnt), 32'd0);
        check("rst_din", 32'(data_in), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_ = 1'b1;

        // ---------------- directed table ----------------
        foreach (vecs[k]) begin
            do_cmd(vecs[k].id, vecs[k].op, vecs[k].val, vecs[k].steps, vecs[k].exp_res);
        end

        // ---------------- round-robin with both requesters always valid ----------------
        @(negedge clk);
        req_op    = {C_UP, C_UP};
        req_steps = {8'd1, 8'd1};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            got = 0;
            for (int t = 0; t < 20; t++) begin
                #1;
                if (req_ready != 2'b00) begin
                    got = 1;
                    break;
                end
                @(negedge clk);
            end
            check("arb_wait_ready", 32'(got), 32'd1);
            exp_g = ~model_last;
            check("arb_grant", 32'(req_ready), exp_g ? 32'd2 : 32'd1);
            got = 0;
            for (int t = 0; t < 20; t++) begin
                @(negedge clk);
                #1;
                if (done) begin
                    got = 1;
                    break;
                end
            end
            check("arb_wait_done", 32'(got), 32'd1);
            check("arb_done_id", 32'(done_id), 32'(exp_g));
            model_val  = model_val + W'(1);
            model_last = exp_g;
            check("arb_result", 32'(result), 32'(model_val));
            @(negedge clk);
        end
        req_valid = 2'b00;

        // ---------------- reset in the middle of a long UP ----------------
        @(negedge clk);
        req_valid       = 2'b01;
        req_op[1:0]     = C_UP;
        req_steps[W-1:0] = 8'd10;
        #1;
        check("rstmid_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #2;
        rst_      = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_ld", 32'(ld_cnt_), 32'd1);
        check("rstmid_enb", 32'(count_enb), 32'd0);
        check("rstmid_updn", 32'(updn_cnt), 32'd0);
        check("rstmid_din", 32'(data_in), 32'd0);
        check("rstmid_result", 32'(result), 32'd0);
        check("rstmid_ready0", 32'(req_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rstmid_hold_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        check("rstmid_first_grant", 32'(req_ready), 32'd1);
        req_valid  = 2'b00;
        model_val  = '0;
        model_last = 1'b1;
        do_cmd(0, C_UP, 8'h00, 1, 8'h01);

        // ---------------- randomized commands ----------------
        for (int r = 0; r < 30; r++) begin
            int           id;
            logic [1:0]   op;
            logic [W-1:0] val;
            int           steps;
            id    = int'($urandom_range(0, 1));
            op    = 2'($urandom_range(0, 3));
            val   = W'($urandom_range(0, 255));
            steps = int'($urandom_range(0, 6));
            do_cmd(id, op, val, steps, predict(op, val, steps, model_val));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
